// File: rtl/imem_program_loader_pkg.sv
// imem_program_loader_pkg: loader state encoding and frame byte-order constants
package imem_program_loader_pkg;
   typedef enum logic [2:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK, S_DONE, S_ERR
   } state_t;
   localparam int BYTE_W = 8;
   localparam int LANES = 4;
endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer: packs big-endian byte lanes into 32-bit words, one-cycle word_valid after lane 3
module imem_word_packer
   import imem_program_loader_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clear,
   input  logic              xfer,
   input  logic [BYTE_W-1:0] data,
   output logic              lane_last,
   output logic              word_valid,
   output logic [31:0]       word
);
   logic [1:0]  lane;
   logic [23:0] sh;
   assign lane_last = lane == 2'(LANES - 1);
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lane <= '0;
         sh <= '0;
         word_valid <= 1'b0;
         word <= '0;
      end else begin
         word_valid <= xfer & lane_last;
         if (clear) lane <= '0;
         else if (xfer) begin
            lane <= lane + 2'd1;
            sh <= {sh[15:0], data};
            if (lane_last) word <= {sh, data};
         end
      end
   end
endmodule

// File: rtl/imem_program_loader.sv
// imem_program_loader: receives a length/data/checksum byte frame, writes words to instruction
// memory and releases the CPU reset only after a verified load
module imem_program_loader
   import imem_program_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          MAX_WORDS = 256
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_data_i,
   output logic        byte_ready_o,
   output logic        im_we_o,
   output logic [31:0] im_addr_o,
   output logic [31:0] im_wdata_o,
   output logic        cpu_rst_n_o,
   output logic        done_o,
   output logic        err_o
);
   localparam int WCW = $clog2(MAX_WORDS + 1);
   state_t state, state_nx;
   logic [7:0]     len_hi, chk;
   logic [15:0]    len;
   logic [WCW-1:0] n_words, word_cnt;
   logic           xfer, start_ok, lane_last, word_done;
   assign len = {len_hi, byte_data_i};
   assign byte_ready_o = state inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK};
   assign xfer = byte_valid_i & byte_ready_o;
   assign start_ok = start_i & (state inside {S_IDLE, S_DONE, S_ERR});
   assign word_done = xfer & (state == S_DATA) & lane_last;
   assign cpu_rst_n_o = state == S_DONE;
   assign done_o = state == S_DONE;
   assign err_o = state == S_ERR;
   imem_word_packer u_packer (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clear      (start_ok),
      .xfer       (xfer & (state == S_DATA)),
      .data       (byte_data_i),
      .lane_last  (lane_last),
      .word_valid (im_we_o),
      .word       (im_wdata_o)
   );
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= S_IDLE;
         len_hi <= '0;
         n_words <= '0;
         word_cnt <= '0;
         chk <= '0;
         im_addr_o <= BASE_ADDR;
      end else begin
         state <= state_nx;
         if (start_ok) begin
            chk <= '0;
            word_cnt <= '0;
         end
         if (xfer && state == S_LEN_HI) len_hi <= byte_data_i;
         if (xfer && state == S_LEN_LO) n_words <= WCW'(len);
         if (xfer && state == S_DATA) chk <= chk ^ byte_data_i;
         // address is registered alongside the packed word so both appear with im_we_o
         if (word_done) begin
            word_cnt <= word_cnt + WCW'(1);
            im_addr_o <= BASE_ADDR + (32'(word_cnt) << 2);
         end
      end
   end
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE, S_DONE, S_ERR: if (start_ok) state_nx = S_LEN_HI;
         S_LEN_HI: if (xfer) state_nx = S_LEN_LO;
         S_LEN_LO: if (xfer) state_nx = (len == 16'd0) ? S_CHECK : (len > 16'(MAX_WORDS)) ? S_ERR : S_DATA;
         S_DATA: if (word_done && word_cnt == n_words - WCW'(1)) state_nx = S_CHECK;
         S_CHECK: if (xfer) state_nx = (byte_data_i == chk) ? S_DONE : S_ERR;
         default: state_nx = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_imem_program_loader.sv
// tb_imem_program_loader: directed frames with a write scoreboard checked by a negedge monitor
module tb_imem_program_loader;
   localparam logic [31:0] BASE = 32'h0000_0000;
   localparam int MAXW = 256;
   logic        clk = 1'b0;
   logic        rst, start, bv;
   logic [7:0]  bd;
   logic        ready, we, cpu_rst_n, done, err;
   logic [31:0] addr, wdata;
   int          vectors = 0, miscompares = 0;
   logic [63:0] sb[$];
   logic [31:0] wq[$];
   logic [63:0] exp_wr;

   imem_program_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start),
      .byte_valid_i (bv),
      .byte_data_i  (bd),
      .byte_ready_o (ready),
      .im_we_o      (we),
      .im_addr_o    (addr),
      .im_wdata_o   (wdata),
      .cpu_rst_n_o  (cpu_rst_n),
      .done_o       (done),
      .err_o        (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (we === 1'b1) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_write: addr %h data %h, none expected", addr, wdata);
         end else begin
            exp_wr = sb.pop_front();
            check("wr_addr", addr, exp_wr[63:32]);
            check("wr_data", wdata, exp_wr[31:0]);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit rnd);
      int n;
      if (rnd)
         for (int k = 0; k < 8 && $urandom_range(1) == 1; k++) begin
            @(negedge clk);
            bv = 1'b0;
            bd = 8'($urandom);
         end
      @(negedge clk);
      bv = 1'b1;
      bd = b;
      n = 0;
      while (!ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!ready) begin
         vectors++;
         miscompares++;
         $display("FAIL byte_timeout: ready %b expected 1", ready);
      end
      @(posedge clk);
      #1 bv = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("cpu_rst_low_in_load", cpu_rst_n, 0);
   endtask

   task automatic send_word(input logic [31:0] w, input bit rnd);
      for (int l = 0; l < 4; l++) send_byte(w[31-8*l -: 8], rnd);
   endtask

   task automatic send_frame(input logic [15:0] n, input logic [7:0] chk, input bit rnd);
      if (n <= MAXW)
         for (int i = 0; i < int'(n); i++) sb.push_back({BASE + 32'(i) * 4, wq[i]});
      pulse_start();
      send_byte(n[15:8], rnd);
      send_byte(n[7:0], rnd);
      if (n <= MAXW) begin
         for (int i = 0; i < int'(n); i++) send_word(wq[i], rnd);
         send_byte(chk, rnd);
      end
   endtask

   task automatic expect_end(input string tag, input logic d);
      int n = 0;
      while (!(done || err) && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      check({tag, "_done"}, done, d);
      check({tag, "_err"}, err, !d);
      check({tag, "_cpu_rst_n"}, cpu_rst_n, d);
      check({tag, "_pending_writes"}, sb.size(), 0);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_ready"}, ready, 0);
      check({tag, "_we"}, we, 0);
      check({tag, "_addr"}, addr, BASE);
      check({tag, "_wdata"}, wdata, 0);
      check({tag, "_cpu_rst_n"}, cpu_rst_n, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_err"}, err, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      start = 1'b0;
      bv = 1'b0;
      bd = 8'h00;
      repeat (3) @(negedge clk);
      check_reset("reset");
      rst = 1'b0;

      wq = '{32'h2001_0005, 32'h0000_0000};
      send_frame(16'd2, 8'h24, 1'b0);
      expect_end("n2", 1'b1);

      check("done_before_restart_cpu", cpu_rst_n, 1);
      wq = '{32'hDEAD_BEEF};
      send_frame(16'd1, 8'h22, 1'b0);
      expect_end("reload", 1'b1);

      send_frame(16'd0, 8'h00, 1'b0);
      expect_end("n0_good", 1'b1);
      send_frame(16'd0, 8'h01, 1'b0);
      expect_end("n0_bad", 1'b0);

      send_frame(16'h0101, 8'h00, 1'b0);
      @(negedge clk);
      check("toolong_err", err, 1);
      check("toolong_ready", ready, 0);
      bv = 1'b1;
      bd = 8'hAA;
      repeat (5) @(negedge clk);
      bv = 1'b0;
      check("toolong_err_held", err, 1);
      check("toolong_cpu_rst_n", cpu_rst_n, 0);
      check("toolong_no_writes", sb.size(), 0);

      wq = '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC, 32'hDDEE_FF00};
      send_frame(16'd4, 8'h00, 1'b0);
      expect_end("n4_gapfree", 1'b1);
      send_frame(16'd4, 8'h00, 1'b1);
      expect_end("n4_random", 1'b1);

      wq = '{32'hCAFE_F00D, 32'h0BAD_C0DE};
      sb.push_back({BASE, wq[0]});
      pulse_start();
      send_byte(8'h00, 1'b0);
      send_byte(8'h02, 1'b0);
      send_word(wq[0], 1'b0);
      send_byte(8'h0B, 1'b0);
      send_byte(8'hAD, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset("midload_rst");
      repeat (3) @(negedge clk);
      check("midload_pending_writes", sb.size(), 0);
      check("midload_cpu_held", cpu_rst_n, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
